// File: rtl/mda_hbridge_deadtime.sv
// Per-motor H-bridge gate sequencer: turns {enable, dir, pwm} into four gate drives.
// Every switch between drive states passes through an all-off dead time; a reversal uses a longer coast.
module mda_hbridge_deadtime #(
  parameter int unsigned DEADTIME_CYC = 25,
  parameter int unsigned REV_DEAD_CYC = 5000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_in,
  input  logic       dir_in,
  input  logic       pwm_in,
  input  logic       fault_clr,
  output logic [3:0] hb_out,
  output logic       dead_busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    StOff,
    StDead,
    StFwdDrv,
    StFwdFree,
    StRevDrv,
    StRevFree
  } state_t;

  localparam logic [CNT_W:0] LReqDt  = (CNT_W + 1)'(DEADTIME_CYC);
  localparam logic [CNT_W:0] LReqRev = (CNT_W + 1)'(REV_DEAD_CYC);
  localparam logic           LParBad = (DEADTIME_CYC == 0) || (REV_DEAD_CYC < DEADTIME_CYC);

  logic             r_en, r_dir, r_pwm;
  state_t           r_state, w_state_d, w_tgt;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_last_vld, w_last_vld_d;
  logic             r_last_dir, w_last_dir_d;
  logic [3:0]       r_hb_out;
  logic             r_fault, w_fault_d, w_fault_cause;
  logic [CNT_W:0]   w_req, w_cnt_inc;
  logic             w_is_drive, w_is_rev;

  function automatic logic [3:0] hb_of(input state_t s);
    case (s)
      StFwdDrv:  hb_of = 4'b1001;
      StFwdFree: hb_of = 4'b0101;
      StRevDrv:  hb_of = 4'b0110;
      StRevFree: hb_of = 4'b0101;
      default:   hb_of = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en  <= 1'b0;
      r_dir <= 1'b0;
      r_pwm <= 1'b0;
    end else begin
      r_en  <= en_in;
      r_dir <= dir_in;
      r_pwm <= pwm_in;
    end
  end

  always_comb begin
    if (!r_en)      w_tgt = StOff;
    else if (!r_dir) w_tgt = r_pwm ? StFwdDrv : StFwdFree;
    else             w_tgt = r_pwm ? StRevDrv : StRevFree;
  end

  assign w_is_drive    = (r_state == StFwdDrv) || (r_state == StFwdFree) ||
                         (r_state == StRevDrv) || (r_state == StRevFree);
  assign w_is_rev      = (r_state == StRevDrv) || (r_state == StRevFree);
  assign w_req         = (r_last_vld && (r_last_dir != r_dir)) ? LReqRev : LReqDt;
  assign w_cnt_inc     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_fault_cause = (r_hb_out[3] & r_hb_out[2]) | (r_hb_out[1] & r_hb_out[0]) | LParBad;
  // A new fault cause beats a simultaneous clear.
  assign w_fault_d     = w_fault_cause | (r_fault & ~fault_clr);

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_last_vld_d = r_last_vld;
    w_last_dir_d = r_last_dir;
    if (w_fault_d || (w_tgt == StOff)) begin
      w_state_d = StOff;
    end else begin
      case (r_state)
        StOff: begin
          w_state_d = StDead;
          w_cnt_d   = '0;
        end
        StDead: begin
          if (w_cnt_inc >= w_req) w_state_d = w_tgt;
          else if (!(&r_cnt))     w_cnt_d   = w_cnt_inc[CNT_W-1:0];
        end
        default: begin
          if (w_tgt != r_state) begin
            w_state_d = StDead;
            w_cnt_d   = '0;
          end
        end
      endcase
    end
    // Remember the direction of any drive state we leave, including into OFF, so a
    // reversal that detours through OFF still gets the long coast.
    if (w_is_drive && (w_state_d != r_state)) begin
      w_last_vld_d = 1'b1;
      w_last_dir_d = w_is_rev;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StOff;
      r_cnt      <= '0;
      r_last_vld <= 1'b0;
      r_last_dir <= 1'b0;
      r_hb_out   <= 4'b0000;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_last_vld <= w_last_vld_d;
      r_last_dir <= w_last_dir_d;
      r_hb_out   <= hb_of(w_state_d);
      r_fault    <= w_fault_d;
    end
  end

  assign hb_out    = r_fault ? 4'b0000 : r_hb_out;
  assign dead_busy = (r_state == StDead);
  assign fault     = r_fault;

endmodule
